// File: rtl/irq_pkg.sv
// irq_pkg: shared constants, state encoding and bus request payload for the interrupt controller.
package irq_pkg;

  localparam int unsigned REG_W    = 8;
  localparam int unsigned ID_W     = 3;
  localparam int unsigned OFF_W    = 2;
  localparam int unsigned WIN_SIZE = 4;

  localparam logic [OFF_W-1:0] OFF_MASK = 2'd0;
  localparam logic [OFF_W-1:0] OFF_PEND = 2'd1;
  localparam logic [OFF_W-1:0] OFF_ID   = 2'd2;
  localparam logic [OFF_W-1:0] OFF_EOI  = 2'd3;

  localparam logic [REG_W-1:0] ID_NONE  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAISE   = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // Decoded access to the register window for the current cycle.
  typedef struct packed {
    logic             wr;
    logic             rd;
    logic [OFF_W-1:0] off;
    logic [REG_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/irq_controller_if.sv
// irq_controller_if: processor bus address/strobe and interrupt handshake signals.
interface irq_controller_if;
  import irq_pkg::*;

  logic [REG_W-1:0] BUS_ADDR;
  logic             BUS_WE;
  logic             BUS_INTERRUPT_RAISE;
  logic             BUS_INTERRUPT_ACK;
  logic             bus_data_oe;

  modport master (
    output BUS_ADDR,
    output BUS_WE,
    output BUS_INTERRUPT_ACK,
    input  BUS_INTERRUPT_RAISE,
    input  bus_data_oe
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_WE,
    input  BUS_INTERRUPT_ACK,
    output BUS_INTERRUPT_RAISE,
    output bus_data_oe
  );

endinterface

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: combinational fixed-priority encoder, bit 0 is highest priority.
module irq_priority_encoder
  import irq_pkg::*;
(
  input  logic [REG_W-1:0] vec_i,
  output logic             valid_c,
  output logic [ID_W-1:0]  idx_c
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    valid_c = |vec_i;
    idx_c   = '0;
    for (int i = REG_W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_c = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// irq_controller: bus-mapped controller merging up to eight interrupt requests into one
// prioritised processor interrupt with mask, pending, in-service id and end-of-interrupt.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'hE0,
  parameter int unsigned NUM_SRC   = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  output logic [NUM_SRC-1:0] IRQ_ACK_OUT,
  inout  wire  [REG_W-1:0]   BUS_DATA,
  irq_controller_if.slave    bus
);

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] sync_q, hist_q, rise;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pend_q, pend_d, pend_clr;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [REG_W-1:0]   active_id_q, active_id_d;
  logic               raise_q, raise_d;
  logic [REG_W-1:0]   rdata_q, rdata_d;
  logic               oe_q, oe_d;

  logic [REG_W-1:0]   mask_w, pend_w, elig_w, id_onehot, off_full;
  logic               elig_valid;
  logic [ID_W-1:0]    elig_idx;
  bus_req_t           req;

  // Window decode; the subtraction handles any base alignment.
  always_comb begin
    off_full  = REG_W'(bus.BUS_ADDR - BASE_ADDR);
    req.wr    = bus.BUS_WE && (off_full < REG_W'(WIN_SIZE));
    req.rd    = !bus.BUS_WE && (off_full < REG_W'(WIN_SIZE));
    req.off   = off_full[OFF_W-1:0];
    req.wdata = BUS_DATA;
  end

  assign rise      = sync_q & ~hist_q;
  assign mask_w    = REG_W'(mask_q);
  assign pend_w    = REG_W'(pend_q);
  assign elig_w    = pend_w & mask_w;
  assign id_onehot = REG_W'(1) << id_q;

  irq_priority_encoder u_prio (
    .vec_i   (elig_w),
    .valid_c (elig_valid),
    .idx_c   (elig_idx)
  );

  // Next-state, register-update and read-mux logic.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    active_id_d = active_id_q;
    mask_d      = mask_q;
    ack_d       = '0;
    pend_clr    = '0;
    rdata_d     = '0;
    oe_d        = req.rd;

    if (req.wr && (req.off == OFF_MASK)) begin
      mask_d = req.wdata[NUM_SRC-1:0];
    end
    if (req.wr && (req.off == OFF_PEND)) begin
      pend_clr = req.wdata[NUM_SRC-1:0];
    end

    unique case (state_q)
      IDLE: begin
        if (elig_valid) begin
          id_d    = elig_idx;
          state_d = RAISE;
        end
      end
      RAISE: begin
        // An acknowledge beats a same-cycle mask drop: the raise was already visible.
        if (bus.BUS_INTERRUPT_ACK) begin
          pend_clr    = pend_clr | id_onehot[NUM_SRC-1:0];
          ack_d       = id_onehot[NUM_SRC-1:0];
          active_id_d = REG_W'(id_q);
          state_d     = SERVICE;
        end else if (!mask_w[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (req.wr && (req.off == OFF_EOI)) begin
          active_id_d = ID_NONE;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new edge outranks a same-cycle clear.
    pend_d  = (pend_q & ~pend_clr) | rise;
    raise_d = (state_d == RAISE);

    if (req.rd) begin
      case (req.off)
        OFF_MASK: rdata_d = mask_w;
        OFF_PEND: rdata_d = pend_w;
        OFF_ID:   rdata_d = active_id_q;
        default:  rdata_d = '0;
      endcase
    end
  end

  // State and register update; reset seeds edge history from the live inputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      sync_q      <= IRQ_IN;
      hist_q      <= IRQ_IN;
      mask_q      <= '0;
      pend_q      <= '0;
      ack_q       <= '0;
      id_q        <= '0;
      active_id_q <= ID_NONE;
      raise_q     <= 1'b0;
      rdata_q     <= '0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= IRQ_IN;
      hist_q      <= sync_q;
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      ack_q       <= ack_d;
      id_q        <= id_d;
      active_id_q <= active_id_d;
      raise_q     <= raise_d;
      rdata_q     <= rdata_d;
      oe_q        <= oe_d;
    end
  end

  assign IRQ_ACK_OUT             = ack_q;
  assign bus.BUS_INTERRUPT_RAISE = raise_q;
  assign bus.bus_data_oe         = oe_q;
  assign BUS_DATA                = oe_q ? rdata_q : 'z;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: scenario tasks plus a randomized service loop against a pending/mask model.
module tb_irq_controller;

  localparam logic [7:0] A_MASK = 8'hE0;
  localparam logic [7:0] A_PEND = 8'hE1;
  localparam logic [7:0] A_ID   = 8'hE2;
  localparam logic [7:0] A_EOI  = 8'hE3;
  localparam logic [7:0] A_IDLE = 8'h10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] irq_ack;
  logic       tb_drv;
  logic [7:0] tb_wdata;
  wire  [7:0] bus_data;

  int         checks;
  int         failures;
  logic [7:0] m_pend;

  irq_controller_if bus_if ();

  assign bus_data = tb_drv ? tb_wdata : 'z;

  irq_controller #(.BASE_ADDR(8'hE0), .NUM_SRC(8)) dut (
    .CLK         (clk),
    .RESET       (rst),
    .IRQ_IN      (irq_in),
    .IRQ_ACK_OUT (irq_ack),
    .BUS_DATA    (bus_data),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    bus_if.BUS_ADDR = addr;
    bus_if.BUS_WE   = 1'b1;
    tb_wdata        = data;
    tb_drv          = 1'b1;
    tick();
    bus_if.BUS_WE   = 1'b0;
    bus_if.BUS_ADDR = A_IDLE;
    tb_drv          = 1'b0;
  endtask

  // Returns data/enable seen one cycle after the address, then idles one cycle.
  task automatic bus_read(input logic [7:0] addr, output logic [7:0] data, output logic oe);
    bus_if.BUS_ADDR = addr;
    bus_if.BUS_WE   = 1'b0;
    tick();
    data            = bus_data;
    oe              = bus_if.bus_data_oe;
    bus_if.BUS_ADDR = A_IDLE;
    tick();
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    irq_in = v;
    tick();
    irq_in = 8'h00;
  endtask

  task automatic wait_raise(input int budget, output logic seen);
    int c = 0;
    while (bus_if.BUS_INTERRUPT_RAISE !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    seen = (bus_if.BUS_INTERRUPT_RAISE === 1'b1);
  endtask

  task automatic send_ack();
    bus_if.BUS_INTERRUPT_ACK = 1'b1;
    tick();
    bus_if.BUS_INTERRUPT_ACK = 1'b0;
  endtask

  task automatic count_raise(input int n, output int hits);
    hits = 0;
    repeat (n) begin
      tick();
      if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) hits++;
    end
  endtask

  // Lowest-index pending source that is also enabled, or -1.
  function automatic int model_pick(input logic [7:0] pend, input logic [7:0] mask);
    for (int i = 0; i < 8; i++) begin
      if (pend[i] && mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    logic [7:0] rd;
    logic       oe;
    repeat (3) tick();
    checks++; if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin failures++; $display("FAIL rst_raise got=%b exp=0", bus_if.BUS_INTERRUPT_RAISE); end
    checks++; if (irq_ack !== 8'h00) begin failures++; $display("FAIL rst_ack got=%h exp=00", irq_ack); end
    checks++; if (bus_if.bus_data_oe !== 1'b0) begin failures++; $display("FAIL rst_oe got=%b exp=0", bus_if.bus_data_oe); end
    rst = 1'b0;
    tick();
    bus_read(A_MASK, rd, oe);
    checks++; if (rd !== 8'h00 || oe !== 1'b1) begin failures++; $display("FAIL rst_mask got=%h/%b exp=00/1", rd, oe); end
    checks++; if (bus_if.bus_data_oe !== 1'b0) begin failures++; $display("FAIL read_oe_one_cycle got=%b exp=0", bus_if.bus_data_oe); end
    bus_read(A_PEND, rd, oe);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rst_pend got=%h exp=00", rd); end
    bus_read(A_ID, rd, oe);
    checks++; if (rd !== 8'hFF) begin failures++; $display("FAIL rst_id got=%h exp=ff", rd); end
    bus_read(A_EOI, rd, oe);
    checks++; if (rd !== 8'h00 || oe !== 1'b1) begin failures++; $display("FAIL eoi_read got=%h/%b exp=00/1", rd, oe); end
  endtask

  task automatic test_basic();
    logic [7:0] rd;
    logic       oe;
    bus_write(A_MASK, 8'h04);
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    checks++; if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin failures++; $display("FAIL lat1 got=%b exp=0", bus_if.BUS_INTERRUPT_RAISE); end
    tick();
    checks++; if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin failures++; $display("FAIL lat2 got=%b exp=0", bus_if.BUS_INTERRUPT_RAISE); end
    tick();
    checks++; if (bus_if.BUS_INTERRUPT_RAISE !== 1'b1) begin failures++; $display("FAIL lat3 got=%b exp=1", bus_if.BUS_INTERRUPT_RAISE); end
    send_ack();
    checks++; if (irq_ack !== 8'h04 || bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin failures++; $display("FAIL basic_ack got=%h/%b exp=04/0", irq_ack, bus_if.BUS_INTERRUPT_RAISE); end
    tick();
    checks++; if (irq_ack !== 8'h00) begin failures++; $display("FAIL ack_one_cycle got=%h exp=00", irq_ack); end
    bus_read(A_ID, rd, oe);
    checks++; if (rd !== 8'h02) begin failures++; $display("FAIL basic_id got=%h exp=02", rd); end
    bus_read(A_PEND, rd, oe);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL basic_pend got=%h exp=00", rd); end
    bus_write(A_EOI, 8'h5A);
    bus_read(A_ID, rd, oe);
    checks++; if (rd !== 8'hFF) begin failures++; $display("FAIL basic_eoi_id got=%h exp=ff", rd); end
  endtask

  task automatic test_priority();
    logic [7:0] rd;
    logic       oe;
    logic       seen;
    bus_write(A_MASK, 8'hFF);
    pulse_irq(8'h22);
    wait_raise(8, seen);
    checks++; if (!seen) begin failures++; $display("FAIL prio_raise1 got=0 exp=1"); end
    send_ack();
    checks++; if (irq_ack !== 8'h02) begin failures++; $display("FAIL prio_first got=%h exp=02", irq_ack); end
    bus_read(A_ID, rd, oe);
    checks++; if (rd !== 8'h01) begin failures++; $display("FAIL prio_id1 got=%h exp=01", rd); end
    bus_write(A_EOI, 8'h00);
    wait_raise(8, seen);
    checks++; if (!seen) begin failures++; $display("FAIL prio_raise2 got=0 exp=1"); end
    send_ack();
    checks++; if (irq_ack !== 8'h20) begin failures++; $display("FAIL prio_second got=%h exp=20", irq_ack); end
    bus_read(A_ID, rd, oe);
    checks++; if (rd !== 8'h05) begin failures++; $display("FAIL prio_id5 got=%h exp=05", rd); end
    bus_write(A_EOI, 8'h00);
  endtask

  task automatic test_no_nesting();
    logic seen;
    int   hits;
    bus_write(A_MASK, 8'hFF);
    pulse_irq(8'h08);
    wait_raise(8, seen);
    send_ack();
    checks++; if (irq_ack !== 8'h08) begin failures++; $display("FAIL nest_ack3 got=%h exp=08", irq_ack); end
    pulse_irq(8'h01);
    count_raise(6, hits);
    checks++; if (hits != 0) begin failures++; $display("FAIL nest_hold got=%0d exp=0", hits); end
    bus_write(A_EOI, 8'h00);
    checks++; if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin failures++; $display("FAIL eoi_edge got=%b exp=0", bus_if.BUS_INTERRUPT_RAISE); end
    tick();
    checks++; if (bus_if.BUS_INTERRUPT_RAISE !== 1'b1) begin failures++; $display("FAIL eoi_plus1 got=%b exp=1", bus_if.BUS_INTERRUPT_RAISE); end
    send_ack();
    checks++; if (irq_ack !== 8'h01) begin failures++; $display("FAIL nest_ack0 got=%h exp=01", irq_ack); end
    bus_write(A_EOI, 8'h00);
  endtask

  task automatic test_masked();
    logic [7:0] rd;
    logic       oe;
    int         hits;
    bus_write(A_MASK, 8'h00);
    pulse_irq(8'h80);
    count_raise(5, hits);
    checks++; if (hits != 0) begin failures++; $display("FAIL masked_raise got=%0d exp=0", hits); end
    bus_read(A_PEND, rd, oe);
    checks++; if (rd !== 8'h80) begin failures++; $display("FAIL masked_pend got=%h exp=80", rd); end
    bus_write(8'hE4, 8'hFF);
    bus_write(8'hDF, 8'hFF);
    bus_read(A_MASK, rd, oe);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL outside_write got=%h exp=00", rd); end
    bus_read(8'hE4, rd, oe);
    checks++; if (oe !== 1'b0) begin failures++; $display("FAIL outside_read_oe got=%b exp=0", oe); end
    bus_write(A_PEND, 8'h80);
    bus_read(A_PEND, rd, oe);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL w1c got=%h exp=00", rd); end
    bus_write(A_MASK, 8'h80);
    count_raise(5, hits);
    checks++; if (hits != 0) begin failures++; $display("FAIL cleared_raise got=%0d exp=0", hits); end
    // Edge detected on the same edge as the W1C write of that bit.
    irq_in = 8'h40;
    tick();
    irq_in = 8'h00;
    bus_write(A_PEND, 8'h40);
    bus_read(A_PEND, rd, oe);
    checks++; if (rd !== 8'h40) begin failures++; $display("FAIL capture_wins got=%h exp=40", rd); end
    bus_write(A_PEND, 8'h40);
    bus_read(A_PEND, rd, oe);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL w1c_after got=%h exp=00", rd); end
    bus_write(A_MASK, 8'h00);
  endtask

  task automatic test_mask_change();
    logic [7:0] rd;
    logic       oe;
    logic       seen;
    bus_write(A_MASK, 8'h04);
    pulse_irq(8'h05);
    wait_raise(8, seen);
    checks++; if (!seen) begin failures++; $display("FAIL unmask_raise got=0 exp=1"); end
    bus_write(A_MASK, 8'h05);
    tick();
    checks++; if (bus_if.BUS_INTERRUPT_RAISE !== 1'b1) begin failures++; $display("FAIL unmask_hold got=%b exp=1", bus_if.BUS_INTERRUPT_RAISE); end
    send_ack();
    checks++; if (irq_ack !== 8'h04) begin failures++; $display("FAIL no_rearb got=%h exp=04", irq_ack); end
    bus_write(A_EOI, 8'h00);
    wait_raise(8, seen);
    send_ack();
    checks++; if (irq_ack !== 8'h01) begin failures++; $display("FAIL unmask_next got=%h exp=01", irq_ack); end
    bus_write(A_EOI, 8'h00);
    bus_write(A_MASK, 8'h08);
    pulse_irq(8'h08);
    wait_raise(8, seen);
    bus_write(A_MASK, 8'h00);
    tick();
    checks++; if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin failures++; $display("FAIL mask_drop got=%b exp=0", bus_if.BUS_INTERRUPT_RAISE); end
    bus_read(A_PEND, rd, oe);
    checks++; if (rd !== 8'h08) begin failures++; $display("FAIL drop_pend got=%h exp=08", rd); end
    bus_read(A_ID, rd, oe);
    checks++; if (rd !== 8'hFF) begin failures++; $display("FAIL drop_id got=%h exp=ff", rd); end
    bus_write(A_PEND, 8'h08);
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    logic       oe;
    logic       seen;
    int         hits;
    bus_write(A_MASK, 8'hFF);
    irq_in = 8'h10;
    wait_raise(8, seen);
    checks++; if (!seen) begin failures++; $display("FAIL rmid_raise got=0 exp=1"); end
    rst = 1'b1;
    tick();
    checks++; if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin failures++; $display("FAIL rmid_drop got=%b exp=0", bus_if.BUS_INTERRUPT_RAISE); end
    rst = 1'b0;
    bus_read(A_MASK, rd, oe);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rmid_mask got=%h exp=00", rd); end
    bus_read(A_PEND, rd, oe);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rmid_pend got=%h exp=00", rd); end
    bus_read(A_ID, rd, oe);
    checks++; if (rd !== 8'hFF) begin failures++; $display("FAIL rmid_id got=%h exp=ff", rd); end
    bus_write(A_MASK, 8'hFF);
    count_raise(5, hits);
    checks++; if (hits != 0) begin failures++; $display("FAIL rmid_spurious got=%0d exp=0", hits); end
    irq_in = 8'h00;
    bus_write(A_MASK, 8'h00);
  endtask

  task automatic test_random_service();
    logic [7:0] v, mask, rd, exp_ack;
    logic       oe, seen;
    int         id, hits;
    m_pend = 8'h00;
    for (int it = 0; it < 12; it++) begin
      v    = 8'($urandom_range(0, 255));
      mask = 8'($urandom_range(0, 255));
      bus_write(A_MASK, 8'h00);
      pulse_irq(v);
      tick();
      tick();
      m_pend = m_pend | v;
      bus_write(A_MASK, mask);
      id = model_pick(m_pend, mask);
      while (id >= 0) begin
        wait_raise(8, seen);
        checks++; if (!seen) begin failures++; $display("FAIL rnd_raise it=%0d got=0 exp=1", it); end
        repeat ($urandom_range(0, 3)) tick();
        send_ack();
        exp_ack = 8'd1 << id;
        checks++; if (irq_ack !== exp_ack) begin failures++; $display("FAIL rnd_ack it=%0d got=%h exp=%h", it, irq_ack, exp_ack); end
        m_pend[id] = 1'b0;
        bus_read(A_ID, rd, oe);
        checks++; if (rd !== 8'(id)) begin failures++; $display("FAIL rnd_id it=%0d got=%h exp=%h", it, rd, 8'(id)); end
        bus_write(A_EOI, 8'($urandom_range(0, 255)));
        id = model_pick(m_pend, mask);
      end
      count_raise(3, hits);
      checks++; if (hits != 0) begin failures++; $display("FAIL rnd_idle it=%0d got=%0d exp=0", it, hits); end
      bus_read(A_PEND, rd, oe);
      checks++; if (rd !== m_pend) begin failures++; $display("FAIL rnd_pend it=%0d got=%h exp=%h", it, rd, m_pend); end
    end
    bus_write(A_PEND, m_pend);
    m_pend = 8'h00;
    bus_read(A_PEND, rd, oe);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rnd_cleanup got=%h exp=00", rd); end
  endtask

  initial begin
    rst                      = 1'b1;
    irq_in                   = 8'h00;
    tb_drv                   = 1'b0;
    tb_wdata                 = 8'h00;
    bus_if.BUS_ADDR          = A_IDLE;
    bus_if.BUS_WE            = 1'b0;
    bus_if.BUS_INTERRUPT_ACK = 1'b0;
    checks                   = 0;
    failures                 = 0;
    m_pend                   = 8'h00;
    test_reset();
    test_basic();
    test_priority();
    test_no_nesting();
    test_masked();
    test_mask_change();
    test_reset_mid();
    test_random_service();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
